design_switch_controller: RTL



---
 rtl/design_switch_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/design_switch_controller.sv
// Switches one of NUM_DESIGNS user designs onto the shared GPIO pads. Every switch runs the same
// sequence: synchronise the select, drain the pads, hold the new design in reset, then run it.
module design_switch_controller #(
  parameter int unsigned NUM_DESIGNS  = 12,
  parameter int unsigned GPIO_W       = 34,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [SEL_W-1:0]              design_select,
  input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out,
  input  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb,
  output logic [GPIO_W-1:0]             gpio_out,
  output logic [GPIO_W-1:0]             gpio_oeb,
  output logic [NUM_DESIGNS-1:0]        designs_ncs,
  output logic [NUM_DESIGNS-1:0]        designs_n_rst,
  output logic [SEL_W-1:0]              active_design,
  output logic                          busy
);

  localparam int unsigned MaxCyc = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0]  GuardLast = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0]  ResetLast = CntW'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0] MaxSel    = SEL_W'(NUM_DESIGNS);

  typedef enum logic [1:0] {StIdle, StDrain, StRstHold, StRun} state_e;

  logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_q;
  logic [SEL_W-1:0]                  sel_s;
  state_e                            state_q, state_d;
  logic [SEL_W-1:0]                  active_q, active_d;
  logic [SEL_W-1:0]                  target_q, target_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;

  // Out-of-range requests are treated as "no design".
  assign sel_s = (sync_q[SYNC_STAGES-1] > MaxSel) ? '0 : sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], design_select};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      active_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        active_d = '0;
        cnt_d    = '0;
        if (sel_s != '0) state_d = StDrain;
      end
      StDrain: begin
        // Select changes inside the guard window are only looked at on its last cycle.
        if (cnt_q == GuardLast) begin
          target_d = sel_s;
          cnt_d    = '0;
          if (sel_s == '0) begin
            state_d = StIdle;
          end else begin
            state_d  = StRstHold;
            active_d = sel_s;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRstHold: begin
        if (sel_s != target_q) begin
          state_d  = StDrain;
          active_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == ResetLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (sel_s != active_q) begin
          state_d  = StDrain;
          active_d = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Select and gate come only from registered state; the data path is combinational.
  always_comb begin
    gpio_out      = '0;
    gpio_oeb      = '1;
    designs_ncs   = '1;
    designs_n_rst = '0;
    for (int k = 0; k < NUM_DESIGNS; k++) begin
      if (active_q == SEL_W'(k + 1)) begin
        if (state_q == StRun) begin
          gpio_out         = designs_gpio_out[k*GPIO_W +: GPIO_W];
          gpio_oeb         = designs_gpio_oeb[k*GPIO_W +: GPIO_W];
          designs_ncs[k]   = 1'b0;
          designs_n_rst[k] = 1'b1;
        end else if (state_q == StRstHold) begin
          designs_ncs[k] = 1'b0;
        end
      end
    end
    active_design = active_q;
    busy          = (state_q == StDrain) || (state_q == StRstHold);
  end

endmodule
